// File: rtl/banner_pkg.sv
// -----------------------------------------------------------------------------
// banner_pkg
// Shared definitions for the scrolling 7-segment banner:
//   - 4-bit symbol codes (0-9, A, b, C, d, E, blank)
//   - active-low 7-segment patterns, bit order {g,f,e,d,c,b,a}
//   - clamp_len(): limits a requested message length to the buffer depth
// No ports (package).
// -----------------------------------------------------------------------------
package banner_pkg;

    localparam logic [3:0] SYM_0     = 4'h0;
    localparam logic [3:0] SYM_1     = 4'h1;
    localparam logic [3:0] SYM_2     = 4'h2;
    localparam logic [3:0] SYM_3     = 4'h3;
    localparam logic [3:0] SYM_4     = 4'h4;
    localparam logic [3:0] SYM_5     = 4'h5;
    localparam logic [3:0] SYM_6     = 4'h6;
    localparam logic [3:0] SYM_7     = 4'h7;
    localparam logic [3:0] SYM_8     = 4'h8;
    localparam logic [3:0] SYM_9     = 4'h9;
    localparam logic [3:0] SYM_A     = 4'hA;
    localparam logic [3:0] SYM_B     = 4'hB;
    localparam logic [3:0] SYM_C     = 4'hC;
    localparam logic [3:0] SYM_D     = 4'hD;
    localparam logic [3:0] SYM_E     = 4'hE;
    localparam logic [3:0] SYM_BLANK = 4'hF;

    // Active-low segments: a 0 lights the segment.
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Requested lengths beyond the buffer depth use the whole buffer.
    function automatic int unsigned clamp_len(input int unsigned len,
                                              input int unsigned max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/hex7seg_decoder.sv
// -----------------------------------------------------------------------------
// hex7seg_decoder
// Combinational symbol-to-segment decoder.
// Ports:
//   sym  in  4  symbol code (0-9, A, b, C, d, E, F = blank)
//   seg  out 7  active-low segment pattern {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module hex7seg_decoder
    import banner_pkg::*;
(
    input  logic [3:0] sym,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (sym)
            SYM_0:     seg = SEG_0;
            SYM_1:     seg = SEG_1;
            SYM_2:     seg = SEG_2;
            SYM_3:     seg = SEG_3;
            SYM_4:     seg = SEG_4;
            SYM_5:     seg = SEG_5;
            SYM_6:     seg = SEG_6;
            SYM_7:     seg = SEG_7;
            SYM_8:     seg = SEG_8;
            SYM_9:     seg = SEG_9;
            SYM_A:     seg = SEG_A;
            SYM_B:     seg = SEG_B;
            SYM_C:     seg = SEG_C;
            SYM_D:     seg = SEG_D;
            SYM_E:     seg = SEG_E;
            default:   seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/banner_scroller_n.sv
// -----------------------------------------------------------------------------
// banner_scroller_n
// Scrolls a runtime-writable message of up to MSG_MAX symbols across DIGITS
// multiplexed 7-segment digits.
// Ports:
//   clock        in   1        system clock
//   reset        in   1        synchronous active-high reset
//   en           in   1        1 = scroll advances, 0 = frozen (refresh runs)
//   dir          in   1        0 = scroll left (ptr+1), 1 = scroll right (ptr-1)
//   step_period  in   STEP_W   clocks per scroll step (0 behaves as 1)
//   msg_len      in   LEN_W    active length, 0 = blank, clamps to MSG_MAX
//   wr_en        in   1        message write strobe
//   wr_addr      in   ADDR_W   write address (>= MSG_MAX ignored)
//   wr_data      in   4        symbol to write
//   segment      out  7        active-low segments {g..a}, registered
//   anode        out  DIGITS   active-low one-hot digit select, registered
//   step         out  1        one-cycle pulse per scroll advance
// -----------------------------------------------------------------------------
module banner_scroller_n
    import banner_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int MSG_MAX     = 16,
    parameter int REFRESH_DIV = 1024,
    parameter int STEP_W      = 24
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         dir,
    input  logic [STEP_W-1:0]            step_period,
    input  logic [$clog2(MSG_MAX+1)-1:0] msg_len,
    input  logic                         wr_en,
    input  logic [$clog2(MSG_MAX)-1:0]   wr_addr,
    input  logic [3:0]                   wr_data,
    output logic [6:0]                   segment,
    output logic [DIGITS-1:0]            anode,
    output logic                         step
);

    localparam int LEN_W  = $clog2(MSG_MAX + 1);
    localparam int ADDR_W = $clog2(MSG_MAX);
    localparam int REF_W  = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int DIG_W  = $clog2(DIGITS);
    // ptr + digit index stays below MSG_MAX + DIGITS <= 2*MSG_MAX
    localparam int SUM_W  = LEN_W + 1;

    logic [3:0]        msg_q [MSG_MAX];
    logic [3:0]        msg_d [MSG_MAX];
    logic [REF_W-1:0]  ref_q, ref_d;
    logic [DIG_W-1:0]  dig_q, dig_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              step_q, step_d;
    logic [DIGITS-1:0] anode_q, anode_d;
    logic [6:0]        seg_q, seg_d;

    logic [LEN_W-1:0]  len_c;
    logic [LEN_W-1:0]  ptr_w;
    logic [STEP_W-1:0] period_m1;
    logic              ptr_bad;
    logic [SUM_W-1:0]  sum;
    logic [3:0]        sym_sel;
    logic [6:0]        seg_dec;

    assign len_c = LEN_W'(clamp_len(int'(msg_len), MSG_MAX));
    assign ptr_w = LEN_W'(ptr_q);

    // ---------------------------------------------------------------
    // Message buffer
    // ---------------------------------------------------------------
    always_comb begin
        msg_d = msg_q;
        if (wr_en && (int'(wr_addr) < MSG_MAX)) begin
            msg_d[wr_addr] = wr_data;
        end
    end

    // ---------------------------------------------------------------
    // Refresh: slot counter and digit index
    // ---------------------------------------------------------------
    always_comb begin
        ref_d = ref_q + REF_W'(1);
        dig_d = dig_q;
        if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
            ref_d = '0;
            dig_d = (dig_q == DIG_W'(DIGITS - 1)) ? '0 : dig_q + DIG_W'(1);
        end
    end

    // ---------------------------------------------------------------
    // Step timer and scroll pointer
    // ---------------------------------------------------------------
    assign period_m1 = (step_period == '0) ? '0 : step_period - STEP_W'(1);

    // A shrinking msg_len can leave ptr outside the message; the repair
    // cycle takes priority over the timer, which holds for that cycle.
    assign ptr_bad = (len_c == '0) ? (ptr_q != '0) : (ptr_w >= len_c);

    always_comb begin
        cnt_d  = cnt_q;
        ptr_d  = ptr_q;
        step_d = 1'b0;
        if (ptr_bad) begin
            ptr_d = '0;
        end else if (en) begin
            if (cnt_q >= period_m1) begin
                cnt_d  = '0;
                step_d = 1'b1;
                if (len_c != '0) begin
                    if (!dir) begin
                        ptr_d = ((ptr_w + LEN_W'(1)) == len_c) ? '0
                                                                : ptr_q + ADDR_W'(1);
                    end else begin
                        ptr_d = (ptr_q == '0) ? ADDR_W'(len_c - LEN_W'(1))
                                              : ptr_q - ADDR_W'(1);
                    end
                end
            end else begin
                cnt_d = cnt_q + STEP_W'(1);
            end
        end
    end

    // ---------------------------------------------------------------
    // Symbol fetch: (ptr + k) mod L by repeated subtraction. When
    // L < DIGITS the sum can exceed L several times, hence DIGITS passes.
    // ---------------------------------------------------------------
    always_comb begin
        sum = SUM_W'(ptr_q) + SUM_W'(dig_q);
        for (int i = 0; i < DIGITS; i++) begin
            if ((len_c != '0) && (sum >= SUM_W'(len_c))) begin
                sum = sum - SUM_W'(len_c);
            end
        end
    end

    always_comb begin
        sym_sel = SYM_BLANK;
        if (len_c != '0) begin
            sym_sel = msg_q[ADDR_W'(sum)];
        end
    end

    hex7seg_decoder u_dec (
        .sym (sym_sel),
        .seg (seg_dec)
    );

    // Both output registers sample the same state so anode and segment
    // always change on the same edge.
    always_comb begin
        anode_d = ~(DIGITS'(1) << (DIGITS - 1 - int'(dig_q)));
        seg_d   = seg_dec;
    end

    // ---------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MSG_MAX; i++) begin
                msg_q[i] <= 4'(i % 10);
            end
            ref_q   <= '0;
            dig_q   <= '0;
            cnt_q   <= '0;
            ptr_q   <= '0;
            step_q  <= 1'b0;
            anode_q <= '1;
            seg_q   <= SEG_BLANK;
        end else begin
            msg_q   <= msg_d;
            ref_q   <= ref_d;
            dig_q   <= dig_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            step_q  <= step_d;
            anode_q <= anode_d;
            seg_q   <= seg_d;
        end
    end

    assign segment = seg_q;
    assign anode   = anode_q;
    assign step    = step_q;

endmodule
